nmr_voter: RTL and testbench

Parametrised N-modular-redundancy voter that sits between replicated datapath units (ALU replicas, register-read replicas) and the shared downstream logic. Each valid cycle it takes N replica words, produces a per-bit majority over the currently active replicas, and registers the result. It also tracks consecutive mismatches per replica, so single transients are tolerated and persistent faults retire the replica. A software- or controller-driven clear restores all replicas.

---
 rtl/nmr_pkg.sv | 21 ++
 rtl/nmr_bit_vote.sv | 20 ++
 rtl/nmr_voter.sv | 117 +++++++++++
 tb/tb_nmr_voter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/nmr_pkg.sv
// Shared defaults and helpers for the N-modular-redundancy voter.
package nmr_pkg;

   localparam int NMR_N_DEF          = 8;
   localparam int NMR_WIDTH_DEF      = 32;
   localparam int NMR_STRIKE_MAX_DEF = 3;
   localparam int NMR_MIN_ACTIVE_DEF = 3;

   function automatic int strike_w(input int smax);
      return $clog2(smax + 1);
   endfunction

   // Replica count is capped at 16, so a 16-bit popcount covers every N.
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int k = 0; k < 16; k++) c = c + 5'(v[k]);
      return c;
   endfunction

endpackage

// File: rtl/nmr_bit_vote.sv
// Masked strict-majority vote for a single bit column across N replicas.
module nmr_bit_vote
   import nmr_pkg::*;
#(
   parameter int N = NMR_N_DEF
) (
   input  logic [N-1:0] i_bits,
   input  logic [N-1:0] i_mask,
   input  logic [4:0]   i_active,
   output logic         o_bit,
   output logic         o_tie
);

   logic [4:0] w_ones;

   assign w_ones = popcount16(16'(i_bits & i_mask));
   assign o_bit  = {w_ones, 1'b0} >  {1'b0, i_active};
   assign o_tie  = {w_ones, 1'b0} == {1'b0, i_active};

endmodule

// File: rtl/nmr_voter.sv
// N-modular-redundancy voter: per-bit majority over active replicas, registered,
// with per-replica consecutive-mismatch strikes and floor-limited retirement.
module nmr_voter
   import nmr_pkg::*;
#(
   parameter int WIDTH      = NMR_WIDTH_DEF,
   parameter int N          = NMR_N_DEF,
   parameter int STRIKE_MAX = NMR_STRIKE_MAX_DEF,
   parameter int MIN_ACTIVE = NMR_MIN_ACTIVE_DEF,
   localparam int SW        = strike_w(STRIKE_MAX)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic             clear_faults,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err,
   output logic [N-1:0]     active_mask,
   output logic [N*SW-1:0]  strike_cnt,
   output logic             degraded
);

   logic [N-1:0]          r_mask;
   logic [N-1:0][SW-1:0]  r_strike;
   logic                  r_degraded;
   logic                  r_out_valid;
   logic [WIDTH-1:0]      r_out_data;
   logic                  r_out_err;

   logic [4:0]             w_active;
   logic [WIDTH-1:0][N-1:0] w_col;
   logic [WIDTH-1:0]       w_vote;
   logic [WIDTH-1:0]       w_tie;
   logic                   w_err;
   logic [N-1:0]           w_mask_nxt;
   logic [N-1:0][SW-1:0]   w_strike_nxt;
   logic                   w_deg_nxt;

   assign w_active = popcount16(16'(r_mask));

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      for (genvar i = 0; i < N; i++) begin : g_rep
         assign w_col[b][i] = in_data[i*WIDTH + b];
      end
      nmr_bit_vote #(.N(N)) u_vote (
         .i_bits   (w_col[b]),
         .i_mask   (r_mask),
         .i_active (w_active),
         .o_bit    (w_vote[b]),
         .o_tie    (w_tie[b])
      );
   end

   assign w_err = |w_tie;

   // Candidates reaching STRIKE_MAX retire in ascending index order until the
   // active count would drop below MIN_ACTIVE; the rest hold at STRIKE_MAX.
   always_comb begin
      int w_nact;
      w_strike_nxt = r_strike;
      w_mask_nxt   = r_mask;
      w_deg_nxt    = r_degraded;
      w_nact       = int'(w_active);
      if (clear_faults) begin
         w_strike_nxt = '0;
         w_mask_nxt   = '1;
         w_deg_nxt    = 1'b0;
      end else if (in_valid && !w_err) begin
         for (int i = 0; i < N; i++) begin
            if (r_mask[i]) begin
               if (in_data[i*WIDTH +: WIDTH] == w_vote)
                  w_strike_nxt[i] = '0;
               else if (r_strike[i] != SW'(STRIKE_MAX))
                  w_strike_nxt[i] = r_strike[i] + SW'(1);
               if (w_strike_nxt[i] == SW'(STRIKE_MAX)) begin
                  if (w_nact > MIN_ACTIVE) begin
                     w_mask_nxt[i] = 1'b0;
                     w_nact        = w_nact - 1;
                  end else begin
                     w_deg_nxt = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mask      <= '1;
         r_strike    <= '0;
         r_degraded  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_err   <= 1'b0;
      end else begin
         r_mask      <= w_mask_nxt;
         r_strike    <= w_strike_nxt;
         r_degraded  <= w_deg_nxt;
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_out_data <= w_vote;
            r_out_err  <= w_err;
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_err     = r_out_err;
   assign active_mask = r_mask;
   assign strike_cnt  = r_strike;
   assign degraded    = r_degraded;

endmodule

// File: tb/tb_nmr_voter.sv
// Bench for nmr_voter: directed scenarios plus randomized traffic vs. a reference model.
module tb_nmr_voter;

   localparam int N = 8, W = 32, SMAX = 3, MINA = 3, SW = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid;
   logic [N*W-1:0] in_data;
   logic           clear_faults;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic           out_err;
   logic [N-1:0]   active_mask;
   logic [N*SW-1:0] strike_cnt;
   logic           degraded;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   bit           m_mask [N];
   int           m_strike [N];
   bit           m_deg;
   bit           m_ov;
   logic [W-1:0] m_od;
   bit           m_oe;

   nmr_voter #(.WIDTH(W), .N(N), .STRIKE_MAX(SMAX), .MIN_ACTIVE(MINA)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .clear_faults(clear_faults), .out_valid(out_valid), .out_data(out_data),
      .out_err(out_err), .active_mask(active_mask), .strike_cnt(strike_cnt),
      .degraded(degraded)
   );

   always #5 clk = ~clk;

   function automatic logic [N*W-1:0] mk(input logic [W-1:0] base, input logic [W-1:0] alt,
                                        input logic [N-1:0] sel);
      logic [N*W-1:0] d;
      for (int i = 0; i < N; i++) d[i*W +: W] = sel[i] ? alt : base;
      return d;
   endfunction

   function automatic int stk(input int i);
      return int'(strike_cnt[i*SW +: SW]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin m_mask[i] = 1; m_strike[i] = 0; end
      m_deg = 0; m_ov = 0; m_od = '0; m_oe = 0;
   endtask

   task automatic model_step(input logic v, input logic [N*W-1:0] d, input logic c);
      int a, ones, act;
      logic [W-1:0] vote;
      bit err;
      a = 0;
      for (int i = 0; i < N; i++) a += m_mask[i];
      vote = '0; err = 0;
      for (int b = 0; b < W; b++) begin
         ones = 0;
         for (int i = 0; i < N; i++) if (m_mask[i] && d[i*W + b]) ones++;
         if (2*ones > a) vote[b] = 1'b1;
         else if (2*ones == a) err = 1;
      end
      m_ov = v;
      if (v) begin m_od = vote; m_oe = err; end
      if (c) begin
         for (int i = 0; i < N; i++) begin m_mask[i] = 1; m_strike[i] = 0; end
         m_deg = 0;
      end else if (v && !err) begin
         act = a;
         for (int i = 0; i < N; i++) begin
            if (!m_mask[i]) continue;
            if (d[i*W +: W] == vote) m_strike[i] = 0;
            else if (m_strike[i] < SMAX) m_strike[i]++;
            if (m_strike[i] == SMAX) begin
               if (act > MINA) begin m_mask[i] = 0; act--; end
               else m_deg = 1;
            end
         end
      end
   endtask

   task automatic step(input logic v, input logic [N*W-1:0] d, input logic c);
      in_valid = v; in_data = d; clear_faults = c;
      model_step(v, d, c);
      @(posedge clk); #1;
      in_valid = 1'b0; clear_faults = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1; in_valid = 1'b0; clear_faults = 1'b0; in_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
      n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_data got %h want 0", out_data); end
      n_tests++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", out_err); end
      n_tests++; if (active_mask !== 8'hFF) begin n_fail++; $display("FAIL rst_mask got %h want ff", active_mask); end
      n_tests++; if (strike_cnt !== '0) begin n_fail++; $display("FAIL rst_strike got %h want 0", strike_cnt); end
      n_tests++; if (degraded !== 1'b0) begin n_fail++; $display("FAIL rst_degraded got %b want 0", degraded); end
   endtask

   task automatic test_unanimous();
      apply_reset();
      step(1, mk(32'h12345678, 32'h12345678, 8'h00), 0);
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL unan_valid got %b want 1", out_valid); end
      n_tests++; if (out_data !== 32'h12345678) begin n_fail++; $display("FAIL unan_data got %h want 12345678", out_data); end
      n_tests++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL unan_err got %b want 0", out_err); end
      n_tests++; if (strike_cnt !== '0 || active_mask !== 8'hFF) begin n_fail++; $display("FAIL unan_state strike %h mask %h want 0/ff", strike_cnt, active_mask); end
      step(0, '0, 0);
      n_tests++; if (out_valid !== 1'b0 || out_data !== 32'h12345678) begin n_fail++; $display("FAIL unan_hold valid %b data %h want 0/12345678", out_valid, out_data); end
   endtask

   task automatic test_retire();
      apply_reset();
      for (int k = 1; k <= 3; k++) begin
         step(1, mk(32'hA5A5A5A5, 32'hFFFFFFFF, 8'h04), 0);
         n_tests++; if (out_data !== 32'hA5A5A5A5 || out_err !== 1'b0) begin n_fail++; $display("FAIL ret_data%0d got %h err %b want a5a5a5a5/0", k, out_data, out_err); end
         n_tests++; if (stk(2) != k) begin n_fail++; $display("FAIL ret_strike%0d got %0d want %0d", k, stk(2), k); end
      end
      n_tests++; if (active_mask !== 8'hFB) begin n_fail++; $display("FAIL ret_mask got %h want fb", active_mask); end
      step(1, mk(32'hA5A5A5A5, 32'h0, 8'h04), 0);
      n_tests++; if (stk(2) != 3 || active_mask !== 8'hFB) begin n_fail++; $display("FAIL ret_frozen strike %0d mask %h want 3/fb", stk(2), active_mask); end
      n_tests++; if (out_data !== 32'hA5A5A5A5 || degraded !== 1'b0) begin n_fail++; $display("FAIL ret_vote4 got %h deg %b want a5a5a5a5/0", out_data, degraded); end
   endtask

   task automatic test_transient();
      int exp_s [3] = '{1, 2, 0};
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         step(1, mk(32'h0F0F0F0F, (k < 2) ? 32'h0F0F0F0E : 32'h0F0F0F0F, 8'h20), 0);
         n_tests++; if (stk(5) != exp_s[k] || active_mask !== 8'hFF) begin n_fail++; $display("FAIL trans_%0d strike5 %0d mask %h want %0d/ff", k, stk(5), active_mask, exp_s[k]); end
      end
   endtask

   task automatic test_tie();
      apply_reset();
      step(1, mk(32'h0, 32'h1, 8'h02), 0);
      step(1, mk(32'h0, 32'h1, 8'hF0), 0);
      n_tests++; if (out_data !== 32'h0 || out_err !== 1'b1) begin n_fail++; $display("FAIL tie_out got %h err %b want 0/1", out_data, out_err); end
      n_tests++; if (stk(1) != 1 || stk(4) != 0 || active_mask !== 8'hFF) begin n_fail++; $display("FAIL tie_state s1 %0d s4 %0d mask %h want 1/0/ff", stk(1), stk(4), active_mask); end
   endtask

   task automatic test_min_active();
      apply_reset();
      repeat (3) step(1, mk(32'h11111111, 32'h22222222, 8'hC0), 0);
      repeat (3) step(1, mk(32'h11111111, 32'h22222222, 8'h30), 0);
      repeat (3) step(1, mk(32'h11111111, 32'h22222222, 8'h08), 0);
      n_tests++; if (active_mask !== 8'h07 || degraded !== 1'b0) begin n_fail++; $display("FAIL mina_setup mask %h deg %b want 07/0", active_mask, degraded); end
      for (int k = 1; k <= 3; k++) begin
         step(1, mk(32'h11111111, 32'h33333333, 8'h01), 0);
         n_tests++; if (out_err !== 1'b0 || out_data !== 32'h11111111) begin n_fail++; $display("FAIL mina_vote%0d got %h err %b want 11111111/0", k, out_data, out_err); end
      end
      n_tests++; if (stk(0) != 3 || active_mask !== 8'h07 || degraded !== 1'b1) begin n_fail++; $display("FAIL mina_hold s0 %0d mask %h deg %b want 3/07/1", stk(0), active_mask, degraded); end
      step(0, '0, 1);
      n_tests++; if (active_mask !== 8'hFF || strike_cnt !== '0 || degraded !== 1'b0) begin n_fail++; $display("FAIL mina_clear mask %h strike %h deg %b want ff/0/0", active_mask, strike_cnt, degraded); end
   endtask

   task automatic test_clear_same_cycle();
      apply_reset();
      repeat (3) step(1, mk(32'h0, 32'hFFFFFFFF, 8'h04), 0);
      n_tests++; if (active_mask !== 8'hFB) begin n_fail++; $display("FAIL clrsc_setup mask %h want fb", active_mask); end
      // with replica 2 excluded this is 3 vs 4; including it would tie
      step(1, mk(32'h0, 32'hFFFFFFFF, 8'h0F), 1);
      n_tests++; if (out_data !== 32'h0 || out_err !== 1'b0) begin n_fail++; $display("FAIL clrsc_vote got %h err %b want 0/0", out_data, out_err); end
      n_tests++; if (active_mask !== 8'hFF || strike_cnt !== '0) begin n_fail++; $display("FAIL clrsc_state mask %h strike %h want ff/0", active_mask, strike_cnt); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      step(1, mk(32'hA5A5A5A5, 32'hFFFFFFFF, 8'h04), 0);
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre valid %b want 1", out_valid); end
      in_valid = 1'b1; in_data = mk(32'hDEADBEEF, 32'h0, 8'h00);
      #2 reset = 1'b1;
      #1;
      n_tests++; if (out_valid !== 1'b0 || out_data !== '0 || strike_cnt !== '0) begin n_fail++; $display("FAIL arst_now valid %b data %h strike %h want 0/0/0", out_valid, out_data, strike_cnt); end
      in_valid = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      model_reset();
      step(0, '0, 0);
      n_tests++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL arst_after valid %b data %h want 0/0", out_valid, out_data); end
   endtask

   task automatic test_random();
      logic [N*W-1:0]  d;
      logic [W-1:0]    base;
      logic [N-1:0]    em;
      logic [N*SW-1:0] es;
      logic            v, c;
      int              r;
      apply_reset();
      for (int t = 0; t < 400; t++) begin
         base = $urandom;
         for (int i = 0; i < N; i++) begin
            r = $urandom_range(0, 9);
            if (i >= 6 && (t % 100) > 40) r = $urandom_range(0, 3);
            d[i*W +: W] = (r == 0) ? W'($urandom) : (r == 1) ? (base ^ (W'(1) << $urandom_range(0, W-1))) : base;
         end
         v = ($urandom_range(0, 9) < 8);
         c = ($urandom_range(0, 39) == 0);
         step(v, d, c);
         for (int i = 0; i < N; i++) begin em[i] = m_mask[i]; es[i*SW +: SW] = SW'(m_strike[i]); end
         n_tests++; if (out_valid !== m_ov || out_data !== m_od || out_err !== m_oe) begin n_fail++; $display("FAIL rand_out t%0d got %b/%h/%b want %b/%h/%b", t, out_valid, out_data, out_err, m_ov, m_od, m_oe); end
         n_tests++; if (active_mask !== em || strike_cnt !== es || degraded !== m_deg) begin n_fail++; $display("FAIL rand_state t%0d got %h/%h/%b want %h/%h/%b", t, active_mask, strike_cnt, degraded, em, es, m_deg); end
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; clear_faults = 1'b0;
      test_reset();
      test_unanimous();
      test_retire();
      test_transient();
      test_tie();
      test_min_active();
      test_clear_same_cycle();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
